// File: rtl/lz4_pkg.sv
// rtl/lz4_pkg.sv - shared constants and state encodings for the LZ4 byte packer
//
// Purpose: write-mode encodings, the output word size and the packer FSM
// state type, shared by the packer top, its merge helper and the interface.
// Ports:   none (package).

package lz4_pkg;

   // Value of byte_dwordN selecting a single-byte write vs. a four-byte write
   localparam logic LZ4_BYTE_MODE  = 1'b1;
   localparam logic LZ4_DWORD_MODE = 1'b0;

   // Bytes per packed output word
   localparam int LZ4_WORD_BYTES = 4;

   typedef enum logic [1:0] {
      PK_RUN   = 2'd0,
      PK_FLUSH = 2'd1,
      PK_DONE  = 2'd2
   } pk_state_t;

endpackage

// File: rtl/lz4_byte_packer_if.sv
// rtl/lz4_byte_packer_if.sv - write/output handshake bundle of the LZ4 byte packer
//
// Purpose: groups the write side, the packed-word output side, the flush
// handshake and the status signals of lz4_byte_packer.
// Signals:
//   din, byte_dwordN, wr_en, in_ready   write port (1 or 4 bytes per write)
//   flush_req, flush_done               drain request / completion pulse
//   dout, out_bytes, out_valid,
//   out_ready                           packed MSB-first word output
//   byte_count, ovf_err                 fill level, sticky dropped-write flag
// Modports: master = producer/consumer side, slave = packer side.

interface lz4_byte_packer_if #(
   parameter int BUF_BYTES = 8,
   parameter int CNT_W     = $clog2(BUF_BYTES + 1)
) ();

   logic [31:0]      din;
   logic             byte_dwordN;
   logic             wr_en;
   logic             in_ready;
   logic             flush_req;
   logic [31:0]      dout;
   logic [2:0]       out_bytes;
   logic             out_valid;
   logic             out_ready;
   logic             flush_done;
   logic [CNT_W-1:0] byte_count;
   logic             ovf_err;

   modport master (
      output din, byte_dwordN, wr_en, flush_req, out_ready,
      input  in_ready, dout, out_bytes, out_valid, flush_done, byte_count, ovf_err
   );

   modport slave (
      input  din, byte_dwordN, wr_en, flush_req, out_ready,
      output in_ready, dout, out_bytes, out_valid, flush_done, byte_count, ovf_err
   );

endinterface

// File: rtl/lz4_byte_merge.sv
// rtl/lz4_byte_merge.sv - inserts one byte or one dword into the staging buffer
//
// Purpose: combinational insert of 1 byte (data[7:0]) or 4 bytes (data[31:24]
// first) at a byte offset counted from the top (MSB end) of the buffer.
// Ports:
//   shifted  in   staging buffer after any pop, bytes past offset are zero
//   offset   in   byte index of the first free slot
//   data     in   write data
//   mode     in   LZ4_BYTE_MODE or LZ4_DWORD_MODE
//   merged   out  buffer with the new bytes placed behind the surviving data

module lz4_byte_merge
   import lz4_pkg::*;
#(
   parameter int BUF_BYTES = 8,
   parameter int CNT_W     = $clog2(BUF_BYTES + 1)
) (
   input  logic [8*BUF_BYTES-1:0] shifted,
   input  logic [CNT_W-1:0]       offset,
   input  logic [31:0]            data,
   input  logic                   mode,
   output logic [8*BUF_BYTES-1:0] merged
);

   localparam int BW = 8 * BUF_BYTES;

   logic [BW-1:0] lane;
   logic [BW-1:0] placed;

   // The new bytes are first left-justified, then slid down to the free slot.
   // Everything at and below the offset is zero in the incoming buffer, so an
   // OR is enough to drop them in without a mask.
   always_comb begin
      lane = '0;
      if (mode == LZ4_BYTE_MODE) begin
         lane[BW-1 -: 8] = data[7:0];
      end else begin
         lane[BW-1 -: 32] = data;
      end
      placed = lane >> {offset, 3'b000};
      merged = shifted | placed;
   end

endmodule

// File: rtl/lz4_byte_packer.sv
// rtl/lz4_byte_packer.sv - packs a byte/dword write stream into MSB-first 32-bit words
//
// Purpose: sits between the LZ4 token/literal emitter and the output word
// bus. Bytes are staged left-justified in a BUF_BYTES buffer; the top word is
// presented on dout whenever four bytes are present, or as a zero-padded
// partial word while a flush drains the buffer.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, discards all buffered data
//   bus   slave modport of lz4_byte_packer_if (write, output, flush, status)

module lz4_byte_packer
   import lz4_pkg::*;
#(
   parameter int BUF_BYTES = 8
) (
   input  logic                clk,
   input  logic                rst,
   lz4_byte_packer_if.slave    bus
);

   localparam int BW    = 8 * BUF_BYTES;
   localparam int CNT_W = $clog2(BUF_BYTES + 1);

   localparam logic [CNT_W-1:0] WORD_CNT   = CNT_W'(LZ4_WORD_BYTES);
   localparam logic [CNT_W-1:0] PUSH_LIMIT = CNT_W'(BUF_BYTES - LZ4_WORD_BYTES);

   pk_state_t        state_q;
   logic [BW-1:0]    stage_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;

   logic             out_valid_c;
   logic [2:0]       out_bytes_c;
   logic             in_ready_c;
   logic             pop;
   logic             push;
   logic [CNT_W-1:0] popped;
   logic [CNT_W-1:0] base_count;
   logic [CNT_W-1:0] push_n;
   logic [CNT_W-1:0] count_d;
   logic [BW-1:0]    shifted;
   logic [BW-1:0]    merged;
   logic [BW-1:0]    stage_d;

   // Handshake decode, all from registered state. in_ready deliberately ignores
   // out_ready so the producer never sees a combinational path from the sink.
   always_comb begin
      out_valid_c = (count_q >= WORD_CNT) || ((state_q == PK_FLUSH) && (count_q != '0));
      out_bytes_c = (count_q >= WORD_CNT) ? 3'd4 : count_q[2:0];
      in_ready_c  = (state_q == PK_RUN) && (count_q <= PUSH_LIMIT);
      pop         = out_valid_c && bus.out_ready;
      push        = bus.wr_en && in_ready_c;
   end

   // Pop is applied before the push: the buffer shifts up a full word (the
   // padding of a partial word is already zero) and the write lands behind
   // whatever survived.
   always_comb begin
      popped     = pop ? CNT_W'(out_bytes_c) : '0;
      shifted    = pop ? (stage_q << 32) : stage_q;
      base_count = count_q - popped;
      push_n     = (bus.byte_dwordN == LZ4_BYTE_MODE) ? CNT_W'(1) : WORD_CNT;
   end

   lz4_byte_merge #(
      .BUF_BYTES (BUF_BYTES),
      .CNT_W     (CNT_W)
   ) u_merge (
      .shifted (shifted),
      .offset  (base_count),
      .data    (bus.din),
      .mode    (bus.byte_dwordN),
      .merged  (merged)
   );

   always_comb begin
      stage_d = push ? merged : shifted;
      count_d = push ? (base_count + push_n) : base_count;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PK_RUN;
         stage_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         stage_q <= stage_d;
         count_q <= count_d;
         if (bus.wr_en && !in_ready_c) begin
            ovf_q <= 1'b1;
         end
         unique case (state_q)
            // A write accepted together with flush_req is already in count_d
            // and therefore drains as part of this flush.
            PK_RUN: begin
               if (bus.flush_req) begin
                  state_q <= PK_FLUSH;
               end
            end
            // No writes are accepted here, so count_d only ever falls.
            PK_FLUSH: begin
               if (count_d == '0) begin
                  state_q <= PK_DONE;
               end
            end
            PK_DONE: begin
               state_q <= PK_RUN;
            end
            default: begin
               state_q <= PK_RUN;
            end
         endcase
      end
   end

   assign bus.dout       = stage_q[BW-1 -: 32];
   assign bus.out_bytes  = out_bytes_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.in_ready   = in_ready_c;
   assign bus.flush_done = (state_q == PK_DONE);
   assign bus.byte_count = count_q;
   assign bus.ovf_err    = ovf_q;

endmodule
